// File: rtl/data_memory_sized_if.sv
// Request/response bus of the sized data memory.
//   master: drives req_valid/req_we/req_size/req_unsigned/req_addr/req_wdata,
//           observes req_ready and the rsp_valid/rsp_rdata/rsp_err response.
//   slave:  the memory side (directions reversed).
interface data_memory_sized_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              rsp_valid;
    logic [63:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_memory_sized.sv
// Byte-addressed data memory with 1/2/4/8-byte little-endian accesses.
// After reset an INIT pass (optional) writes mem[i] = i, one byte per cycle.
// One request is accepted per IDLE cycle; the response appears in the
// following RESP cycle. Misaligned or out-of-range requests are rejected.
// Ports:
//   clk       - single clock, all state changes on posedge
//   reset     - asynchronous, active-low reset
//   bus       - request/response bus (slave side)
//   init_done - high once initialisation has completed
module data_memory_sized #(
    parameter int unsigned DEPTH         = 64,
    parameter int unsigned ADDR_W        = 64,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    data_memory_sized_if.slave bus,
    output logic               init_done
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned ExtW = ADDR_W + 1;

    typedef enum logic [1:0] {StInit, StIdle, StResp} state_e;

    state_e            state_q, state_d;
    logic [7:0]        mem [DEPTH];
    logic [IdxW-1:0]   init_cnt_q;
    logic              init_done_q;
    logic              init_last;
    logic              accept;

    logic [7:0]        byte_en;
    logic [2:0]        align_mask;
    logic [3:0]        n_bytes;
    logic              misaligned;
    logic              out_of_range;
    logic              req_err;
    logic [ExtW-1:0]   end_addr;
    logic [IdxW-1:0]   byte_idx [8];
    logic [63:0]       raw;
    logic [63:0]       ext;

    logic              rsp_err_q;
    logic [63:0]       rsp_rdata_q;

    assign init_last = (init_cnt_q == IdxW'(DEPTH - 1));
    assign accept    = bus.req_valid & bus.req_ready;

    // Size decode and request validity.
    always_comb begin
        byte_en    = '0;
        align_mask = '0;
        n_bytes    = '0;
        unique case (bus.req_size)
            2'd0: begin byte_en = 8'h01; align_mask = 3'b000; n_bytes = 4'd1; end
            2'd1: begin byte_en = 8'h03; align_mask = 3'b001; n_bytes = 4'd2; end
            2'd2: begin byte_en = 8'h0F; align_mask = 3'b011; n_bytes = 4'd4; end
            2'd3: begin byte_en = 8'hFF; align_mask = 3'b111; n_bytes = 4'd8; end
        endcase
        misaligned   = |(bus.req_addr[2:0] & align_mask);
        // One extra bit so the end address cannot wrap back into range.
        end_addr     = {1'b0, bus.req_addr} + ExtW'(n_bytes);
        out_of_range = end_addr > ExtW'(DEPTH);
        req_err      = misaligned | out_of_range;
    end

    // Gather the addressed bytes, little-endian.
    always_comb begin
        raw = '0;
        for (int k = 0; k < 8; k++) begin
            byte_idx[k] = bus.req_addr[IdxW-1:0] + IdxW'(k);
            if (byte_en[k]) begin
                raw[8*k +: 8] = mem[byte_idx[k]];
            end
        end
    end

    // Sign/zero extension; a double needs none.
    always_comb begin
        ext = raw;
        if (!bus.req_unsigned) begin
            unique case (bus.req_size)
                2'd0: ext = {{56{raw[7]}}, raw[7:0]};
                2'd1: ext = {{48{raw[15]}}, raw[15:0]};
                2'd2: ext = {{32{raw[31]}}, raw[31:0]};
                2'd3: ext = raw;
            endcase
        end
    end

    // Memory array: no reset, changed only by INIT or accepted good writes.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            mem[init_cnt_q] <= 8'(init_cnt_q);
        end else if (accept && bus.req_we && !req_err) begin
            for (int k = 0; k < 8; k++) begin
                if (byte_en[k]) begin
                    mem[byte_idx[k]] <= bus.req_wdata[8*k +: 8];
                end
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if (INIT_ON_RESET) state_q <= StInit;
            else               state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:  if (init_last) state_d = StIdle;
            StIdle:  if (accept)    state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Init counter, init-done flag and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            if (state_q == StInit) begin
                init_cnt_q <= init_cnt_q + 1'b1;
            end
            // Without INIT this rises on the first edge after release.
            if (state_q != StInit || init_last) begin
                init_done_q <= 1'b1;
            end
            if (accept) begin
                rsp_err_q   <= req_err;
                rsp_rdata_q <= (req_err || bus.req_we) ? 64'd0 : ext;
            end
        end
    end

    // FSM outputs.
    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state_q)
            StIdle:  bus.req_ready = init_done_q;
            StResp:  bus.rsp_valid = 1'b1;
            default: ;
        endcase
        bus.rsp_rdata = rsp_rdata_q;
        bus.rsp_err   = rsp_err_q;
        init_done     = init_done_q;
    end

endmodule

// File: tb/tb_data_memory_sized.sv
// Self-checking bench for data_memory_sized (DEPTH=64) with a byte-array model.
module tb_data_memory_sized;

    logic clk = 1'b0;
    logic reset;
    logic init_done;
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [7:0] ref_mem [64];

    data_memory_sized_if #(.ADDR_W(64)) bus ();

    data_memory_sized #(
        .DEPTH(64),
        .ADDR_W(64),
        .INIT_ON_RESET(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Reference: reads and writes computed straight from the access rules.
    function automatic void model(input bit we, input logic [1:0] sz, input bit uns,
                                  input logic [63:0] addr, input logic [63:0] wd,
                                  output logic [63:0] rd, output bit er);
        int n = 1 << sz;
        rd = 64'd0;
        er = ((addr % n) != 0) || (addr > 64'(64 - n));
        if (er) return;
        if (we) begin
            for (int k = 0; k < n; k++) ref_mem[addr + k] = wd[8*k +: 8];
        end else begin
            for (int k = 0; k < n; k++) rd = rd | (64'(ref_mem[addr + k]) << (8 * k));
            if (!uns && n < 8 && rd[8*n-1]) rd = rd | (~64'd0 << (8 * n));
        end
    endfunction

    function automatic void model_reinit();
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i);
    endfunction

    task automatic do_req(input bit we, input logic [1:0] sz, input bit uns,
                          input logic [63:0] addr, input logic [63:0] wd,
                          output logic [63:0] rd, output bit er, output bit vld);
        int t = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (bus.req_ready !== 1'b1) $display("FAIL req_ready_wait: ready=%b after %0d cycles, required 1", bus.req_ready, t);
        else n_pass++;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_valid    = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
        vld = bus.rsp_valid;
    endtask

    task automatic test_reset();
        int cyc = 0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 ||
            bus.rsp_rdata !== 64'd0 || init_done !== 1'b0)
            $display("FAIL reset_outputs: ready=%b valid=%b err=%b rdata=%h done=%b, required all 0",
                     bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, init_done);
        else n_pass++;
        reset = 1'b1;
        while (init_done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 10) begin
                n_checks++;
                if (bus.req_ready !== 1'b0 || init_done !== 1'b0)
                    $display("FAIL init_busy: ready=%b done=%b, required 0 0", bus.req_ready, init_done);
                else n_pass++;
            end
        end
        n_checks++;
        if (cyc != 64) $display("FAIL init_length: got %0d cycles, required 64", cyc);
        else n_pass++;
        model_reinit();
    endtask

    task automatic test_directed();
        logic [63:0] rd, mrd;
        bit er, vld, mer;

        do_req(1'b0, 2'd3, 1'b0, 64'd8, 64'd0, rd, er, vld);
        model(1'b0, 2'd3, 1'b0, 64'd8, 64'd0, mrd, mer);
        n_checks++;
        if (rd !== 64'h0F0E0D0C0B0A0908 || er !== 1'b0 || vld !== 1'b1)
            $display("FAIL dbl_read_8: rdata=%h err=%b valid=%b, required 0f0e0d0c0b0a0908 0 1", rd, er, vld);
        else n_pass++;

        do_req(1'b1, 2'd0, 1'b0, 64'd3, 64'h80, rd, er, vld);
        model(1'b1, 2'd0, 1'b0, 64'd3, 64'h80, mrd, mer);
        n_checks++;
        if (rd !== 64'd0 || er !== 1'b0) $display("FAIL byte_write_3: rdata=%h err=%b, required 0 0", rd, er);
        else n_pass++;

        do_req(1'b0, 2'd0, 1'b0, 64'd3, 64'd0, rd, er, vld);
        n_checks++;
        if (rd !== 64'hFFFFFFFFFFFFFF80) $display("FAIL signed_byte_3: rdata=%h, required ffffffffffffff80", rd);
        else n_pass++;

        do_req(1'b0, 2'd0, 1'b1, 64'd3, 64'd0, rd, er, vld);
        n_checks++;
        if (rd !== 64'h0000000000000080) $display("FAIL unsigned_byte_3: rdata=%h, required 80", rd);
        else n_pass++;

        // Restore byte 3 so the half-write scenario starts from the init pattern.
        do_req(1'b1, 2'd0, 1'b0, 64'd3, 64'h03, rd, er, vld);
        model(1'b1, 2'd0, 1'b0, 64'd3, 64'h03, mrd, mer);
        do_req(1'b1, 2'd1, 1'b0, 64'd6, 64'hBEEF, rd, er, vld);
        model(1'b1, 2'd1, 1'b0, 64'd6, 64'hBEEF, mrd, mer);
        do_req(1'b0, 2'd3, 1'b0, 64'd0, 64'd0, rd, er, vld);
        n_checks++;
        if (rd !== 64'hBEEF050403020100 || er !== 1'b0)
            $display("FAIL half_write_6: rdata=%h err=%b, required beef050403020100 0", rd, er);
        else n_pass++;

        do_req(1'b0, 2'd2, 1'b0, 64'd2, 64'd0, rd, er, vld);
        n_checks++;
        if (rd !== 64'd0 || er !== 1'b1) $display("FAIL misaligned_word_2: rdata=%h err=%b, required 0 1", rd, er);
        else n_pass++;

        do_req(1'b1, 2'd3, 1'b0, 64'd64, 64'hDEADBEEFCAFEF00D, rd, er, vld);
        n_checks++;
        if (er !== 1'b1 || rd !== 64'd0) $display("FAIL oob_write_64: err=%b rdata=%h, required 1 0", er, rd);
        else n_pass++;

        do_req(1'b0, 2'd3, 1'b0, 64'd56, 64'd0, rd, er, vld);
        n_checks++;
        if (rd !== 64'h3F3E3D3C3B3A3938 || er !== 1'b0)
            $display("FAIL dbl_read_56: rdata=%h err=%b, required 3f3e3d3c3b3a3938 0", rd, er);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [63:0] rd, mrd, addr, wd;
        logic [1:0] sz;
        bit er, vld, mer, we, uns;
        for (int i = 0; i < 80; i++) begin
            we   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom_range(0, 1));
            addr = 64'($urandom_range(0, 72));
            if ($urandom_range(0, 3) != 0) addr = addr & ~64'((1 << sz) - 1);
            if (i == 5) addr = 64'hFFFF_FFFF_FFFF_FFF8;
            wd = {$urandom, $urandom};
            do_req(we, sz, uns, addr, wd, rd, er, vld);
            model(we, sz, uns, addr, wd, mrd, mer);
            n_checks++;
            if (rd !== mrd || er !== mer || vld !== 1'b1)
                $display("FAIL rand_%0d we=%b sz=%0d uns=%b addr=%h: rdata=%h err=%b valid=%b, required %h %b 1",
                         i, we, sz, uns, addr, rd, er, vld, mrd, mer);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] addr, exp_rd, dummy;
        logic [1:0] sz;
        bit uns, exp_er;
        int t = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) begin
                sz   = 2'($urandom_range(0, 3));
                uns  = 1'($urandom_range(0, 1));
                addr = 64'($urandom_range(0, 63)) & ~64'((1 << sz) - 1);
                model(1'b0, sz, uns, addr, 64'd0, exp_rd, exp_er);
                bus.req_we       = 1'b0;
                bus.req_size     = sz;
                bus.req_unsigned = uns;
                bus.req_addr     = addr;
                bus.req_valid    = 1'b1;
            end
            @(negedge clk);
            n_checks++;
            if (i % 2 == 0) begin
                if (bus.rsp_valid !== 1'b1 || bus.req_ready !== 1'b0 ||
                    bus.rsp_rdata !== exp_rd || bus.rsp_err !== exp_er)
                    $display("FAIL b2b_resp_%0d: valid=%b ready=%b rdata=%h err=%b, required 1 0 %h %b",
                             i, bus.rsp_valid, bus.req_ready, bus.rsp_rdata, bus.rsp_err, exp_rd, exp_er);
                else n_pass++;
            end else begin
                if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
                    $display("FAIL b2b_idle_%0d: valid=%b ready=%b, required 0 1", i, bus.rsp_valid, bus.req_ready);
                else n_pass++;
            end
        end
        bus.req_valid = 1'b0;
        dummy = 64'd0;
    endtask

    task automatic test_reset_mid_init();
        int cyc = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (init_done !== 1'b0 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0)
            $display("FAIL mid_init_reset: done=%b ready=%b valid=%b, required 0 0 0",
                     init_done, bus.req_ready, bus.rsp_valid);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        while (init_done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc != 64) $display("FAIL reinit_length: got %0d cycles, required 64", cyc);
        else n_pass++;
        model_reinit();
    endtask

    task automatic test_reset_in_resp();
        logic [63:0] rd, mrd;
        bit er, vld, mer;
        int cyc = 0;
        do_req(1'b0, 2'd2, 1'b0, 64'd2, 64'd0, rd, er, vld);
        n_checks++;
        if (vld !== 1'b1 || er !== 1'b1) $display("FAIL resp_before_reset: valid=%b err=%b, required 1 1", vld, er);
        else n_pass++;
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 64'd0 ||
            bus.req_ready !== 1'b0 || init_done !== 1'b0)
            $display("FAIL resp_reset_clear: valid=%b err=%b rdata=%h ready=%b done=%b, required all 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, bus.req_ready, init_done);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        while (init_done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc != 64) $display("FAIL resp_reinit_length: got %0d cycles, required 64", cyc);
        else n_pass++;
        model_reinit();
        do_req(1'b0, 2'd3, 1'b1, 64'd16, 64'd0, rd, er, vld);
        model(1'b0, 2'd3, 1'b1, 64'd16, 64'd0, mrd, mer);
        n_checks++;
        if (rd !== mrd || er !== mer) $display("FAIL post_reinit_read: rdata=%h err=%b, required %h %b", rd, er, mrd, mer);
        else n_pass++;
    endtask

    initial begin
        reset            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 64'd0;
        bus.req_wdata    = 64'd0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_init();
        test_reset_in_resp();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
